imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 2048, instruction words held (byte span DEPTH_WORDS*4).
REQ-002 SHALL have parameter INIT_FILE, default "", hex image loaded into storage at elaboration when non-empty.
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req_valid  input  1  fetch request present.
REQ-006 SHALL have port i_req_addr  input  32  byte address of requested instruction.
REQ-007 SHALL have port o_req_ready  output  1  request accepted this cycle when high with i_req_valid.
REQ-008 SHALL have port i_flush  input  1  discard held/in-flight response (pipeline redirect).
REQ-009 SHALL have port o_rsp_valid  output  1  response present.
REQ-010 SHALL have port i_rsp_ready  input  1  consumer takes response this cycle.
REQ-011 SHALL have port o_rsp_data  output  32  instruction word.
REQ-012 SHALL have port o_rsp_addr  output  32  address the response belongs to.
REQ-013 SHALL have port o_rsp_err  output  2  bit0 misaligned, bit1 out-of-range.

Function
REQ-014 SHALL implement two states, EMPTY (no response held) and FULL (response held).
REQ-015 SHALL drive o_req_ready = (state==EMPTY) | i_rsp_ready | i_flush, combinationally.
REQ-016 SHALL on accept (i_req_valid & o_req_ready) perform one synchronous storage read at i_req_addr[31:2], with data at o_rsp_data and o_rsp_valid high on the next cycle (latency 1, throughput 1/cycle).
REQ-017 SHALL hold o_rsp_data, o_rsp_addr, o_rsp_err stable while FULL and i_rsp_ready low; storage read enable asserts only on accept.
REQ-018 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on i_rsp_ready without accept; FULL->FULL on simultaneous consume and accept (new response replaces old next cycle).
REQ-019 SHALL flag misaligned when i_req_addr[1:0]!=0 and out-of-range when i_req_addr >= DEPTH_WORDS*4; either error returns o_rsp_data=32'h00000013 and skips storage read.
REQ-020 SHALL, on i_flush without accept, go EMPTY next cycle; on i_flush with accept, go FULL with the new request's response only.
REQ-021 SHALL ignore i_rsp_ready while EMPTY and ignore i_req_addr when i_req_valid low.
REQ-022 SHALL compute out-of-range compare in 33 bits so DEPTH_WORDS*4 = 2^32 does not wrap.

Reset
REQ-023 SHALL on i_reset high at a rising edge set state EMPTY, o_rsp_valid=0, o_rsp_data=32'h00000013, o_rsp_addr=0, o_rsp_err=0.
REQ-024 SHALL deassert o_req_ready while i_reset high; a request or flush coinciding with reset is dropped.
REQ-025 SHALL not clear storage contents on reset.

Structure
REQ-026 SHALL take NOP constant 32'h00000013, error-bit indices, and state enum from the shared package.
REQ-027 SHALL instantiate one sub-module imem_array (synchronous single-port read storage, INIT_FILE load); handshake FSM stays in imem_responder.

Verification
REQ-028 Image word[k]=32'hA000_0000+k; requests 0x0,0x4,0x8 back-to-back, i_rsp_ready=1 -> responses A0000000,A0000001,A0000002 on cycles 1,2,3, no gaps.
REQ-029 Request 0x10, hold i_rsp_ready=0 for 3 cycles with i_req_valid=1 addr 0x14 -> o_rsp_data stays A0000004, o_req_ready=0; after ready, A0000005 next cycle.
REQ-030 Request 0x6 -> o_rsp_err=2'b01, o_rsp_data=00000013, o_rsp_addr=00000006.
REQ-031 DEPTH_WORDS=2048, request 0x2000 -> o_rsp_err=2'b10, data 00000013; request 0x1FFC -> A00007FF, err 0.
REQ-032 FULL with 0x20 unconsumed, i_flush plus request 0x100 -> next response A0000040 only; flush alone -> o_rsp_valid=0 next cycle.
REQ-033 Assert i_reset while FULL -> next cycle o_rsp_valid=0, data 00000013, o_req_ready=0 until reset drops.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared constants and types for the instruction-memory responder.
// The NOP word, error-bit positions and the handshake state live here.
package imem_responder_pkg;

  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
  localparam int          ERR_MISALIGN = 0;
  localparam int          ERR_RANGE    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  // span is the byte size of storage, 33 bits so a full 4 GiB span does not wrap
  function automatic logic [1:0] addr_err(input logic [31:0] addr,
                                          input logic [32:0] span);
    logic [1:0] err;
    err               = '0;
    err[ERR_MISALIGN] = |addr[1:0];
    err[ERR_RANGE]    = ({1'b0, addr} >= span);
    return err;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-wide instruction storage with a registered, enable-gated read port.
// Reset never touches the stored contents.
module imem_array #(
  parameter int    DEPTH_WORDS = 2048,
  parameter string INIT_FILE   = "",
  parameter int    AW          = 11
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read register holds its value between reads so the response stays stable
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_responder.sv
// Single-entry fetch responder: accepts one request per cycle and returns the
// instruction word one cycle later, holding it until the consumer takes it.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 2048,
  parameter string INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  input  logic        i_flush,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [31:0] o_rsp_addr,
  output logic [1:0]  o_rsp_err
);

  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  rsp_state_e  state_p1;
  logic [31:0] rsp_addr_p1;
  logic [1:0]  rsp_err_p1;
  logic        use_mem_p1;

  logic [1:0]  req_err;
  logic        accept;
  logic        rd_en;
  logic [31:0] rd_data;

  assign req_err     = addr_err(i_req_addr, SPAN);
  assign o_req_ready = ~i_reset & ((state_p1 == ST_EMPTY) | i_rsp_ready | i_flush);
  assign accept      = i_req_valid & o_req_ready;
  assign rd_en       = accept & ~|req_err;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE),
    .AW          (AW)
  ) u_array (
    .clk     (i_clk),
    .rd_en   (rd_en),
    .rd_addr (i_req_addr[AW+1:2]),
    .rd_data (rd_data)
  );

  // ---- stage p1: held response ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_p1    <= ST_EMPTY;
      rsp_addr_p1 <= '0;
      rsp_err_p1  <= '0;
      use_mem_p1  <= 1'b0;
    end else if (accept) begin
      state_p1    <= ST_FULL;
      rsp_addr_p1 <= i_req_addr;
      rsp_err_p1  <= req_err;
      use_mem_p1  <= ~|req_err;
    end else if (i_flush || (state_p1 == ST_FULL && i_rsp_ready)) begin
      state_p1    <= ST_EMPTY;
    end
  end

  // Errored requests never read storage, so the NOP is substituted here
  assign o_rsp_valid = (state_p1 == ST_FULL);
  assign o_rsp_data  = use_mem_p1 ? rd_data : NOP_INSN;
  assign o_rsp_addr  = rsp_addr_p1;
  assign o_rsp_err   = rsp_err_p1;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch handshake.
module tb_imem_responder;

  localparam int          DEPTH = 2048;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_reset, i_req_valid, i_flush, i_rsp_ready;
  logic [31:0] i_req_addr;
  logic        o_req_ready, o_rsp_valid;
  logic [31:0] o_rsp_data, o_rsp_addr;
  logic [1:0]  o_rsp_err;

  int n_vec  = 0;
  int n_fail = 0;

  // model: the single response the consumer should currently see
  bit          m_full;
  logic [31:0] m_data, m_addr;
  logic [1:0]  m_err;
  bit          m_ready, ready_obs;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .o_req_ready (o_req_ready),
    .i_flush     (i_flush),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_addr  (o_rsp_addr),
    .o_rsp_err   (o_rsp_err)
  );

  function automatic logic [31:0] image_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // One clock: drive inputs after the falling edge, sample ready before the
  // rising edge, advance the model, and leave time just after the rising edge.
  task automatic tick(input bit rst, input bit v, input logic [31:0] a,
                      input bit rr, input bit fl);
    @(negedge clk);
    i_reset     = rst;
    i_req_valid = v;
    i_req_addr  = a;
    i_rsp_ready = rr;
    i_flush     = fl;
    #1;
    ready_obs = o_req_ready;
    m_ready   = !rst && (!m_full || rr || fl);
    if (rst) begin
      m_full = 0; m_data = NOP; m_addr = '0; m_err = '0;
    end else if (v && m_ready) begin
      m_full = 1;
      m_addr = a;
      m_err  = {({1'b0, a} >= 33'(DEPTH * 4)), (a[1:0] != 2'b00)};
      m_data = (m_err != 2'b00) ? NOP : image_word(a);
    end else if (fl || (m_full && rr)) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 32'h0, 1, 1);
      n_vec++; if (ready_obs !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_obs); end
    end
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_rsp_valid); end
    n_vec++; if (o_rsp_data !== NOP) begin n_fail++; $display("FAIL reset_data: got %h want %h", o_rsp_data, NOP); end
    n_vec++; if (o_rsp_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", o_rsp_addr); end
    n_vec++; if (o_rsp_err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", o_rsp_err); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 32'(i * 4), 1, 0);
      n_vec++; if (o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, o_rsp_valid); end
      n_vec++; if (o_rsp_data !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, o_rsp_data, 32'hA000_0000 + 32'(i)); end
    end
    tick(0, 0, 32'h0, 1, 0);
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", o_rsp_valid); end
  endtask

  task automatic test_stall();
    tick(0, 1, 32'h10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 32'h14, 0, 0);
      n_vec++; if (ready_obs !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, ready_obs); end
      n_vec++; if (o_rsp_data !== 32'hA000_0004) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want a0000004", i, o_rsp_data); end
    end
    tick(0, 1, 32'h14, 1, 0);
    n_vec++; if (ready_obs !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", ready_obs); end
    n_vec++; if (o_rsp_data !== 32'hA000_0005 || o_rsp_addr !== 32'h14) begin n_fail++; $display("FAIL stall_next: got %h@%h want a0000005@00000014", o_rsp_data, o_rsp_addr); end
    tick(0, 0, 32'h0, 1, 0);
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5];
    logic [31:0] want_d [5];
    logic [1:0]  want_e [5];
    addrs  = '{32'h6, 32'h2000, 32'h1FFC, 32'h2002, 32'hFFFF_FFFC};
    want_d = '{NOP, NOP, 32'hA000_07FF, NOP, NOP};
    want_e = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10};
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, addrs[i], 1, 0);
      n_vec++;
      if (o_rsp_valid !== 1'b1 || o_rsp_err !== want_e[i] || o_rsp_data !== want_d[i] || o_rsp_addr !== addrs[i]) begin
        n_fail++;
        $display("FAIL err_case[%0d]: got v=%b err=%b data=%h addr=%h want v=1 err=%b data=%h addr=%h",
                 i, o_rsp_valid, o_rsp_err, o_rsp_data, o_rsp_addr, want_e[i], want_d[i], addrs[i]);
      end
    end
    tick(0, 0, 32'h0, 1, 0);
  endtask

  task automatic test_flush();
    tick(0, 1, 32'h20, 0, 0);
    tick(0, 1, 32'h100, 0, 1);
    n_vec++; if (ready_obs !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", ready_obs); end
    n_vec++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'hA000_0040 || o_rsp_addr !== 32'h100) begin n_fail++; $display("FAIL flush_replace: got v=%b %h@%h want v=1 a0000040@00000100", o_rsp_valid, o_rsp_data, o_rsp_addr); end
    tick(0, 0, 32'h0, 0, 1);
    n_vec++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_alone: got %b want 0", o_rsp_valid); end
  endtask

  task automatic test_reset_full();
    tick(0, 1, 32'h30, 0, 0);
    n_vec++; if (o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstfull_pre: got %b want 1", o_rsp_valid); end
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 32'h44, 0, 1);
      n_vec++; if (ready_obs !== 1'b0) begin n_fail++; $display("FAIL rstfull_ready[%0d]: got %b want 0", i, ready_obs); end
      n_vec++; if (o_rsp_valid !== 1'b0 || o_rsp_data !== NOP) begin n_fail++; $display("FAIL rstfull_out[%0d]: got v=%b %h want v=0 %h", i, o_rsp_valid, o_rsp_data, NOP); end
    end
    tick(0, 0, 32'h0, 0, 0);
    n_vec++; if (ready_obs !== 1'b1) begin n_fail++; $display("FAIL rstfull_release: got %b want 1", ready_obs); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit rst, v, rr, fl;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       a = {$urandom_range(0, DEPTH - 1), 2'($urandom_range(1, 3))};
        1, 2:    a = $urandom;
        default: a = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00} | (32'($urandom_range(0, DEPTH - 1)) << 2);
      endcase
      rst = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      tick(rst, v, a, rr, fl);
      n_vec++; if (ready_obs !== m_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ready_obs, m_ready); end
      n_vec++; if (o_rsp_valid !== m_full) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, o_rsp_valid, m_full); end
      if (m_full || rst) begin
        n_vec++;
        if (o_rsp_data !== m_data || o_rsp_addr !== m_addr || o_rsp_err !== m_err) begin
          n_fail++;
          $display("FAIL rnd_rsp[%0d]: got %h@%h err=%b want %h@%h err=%b", i, o_rsp_data, o_rsp_addr, o_rsp_err, m_data, m_addr, m_err);
        end
      end
    end
  endtask

  initial begin
    i_reset = 1; i_req_valid = 0; i_req_addr = '0; i_rsp_ready = 0; i_flush = 0;
    m_full = 0; m_data = NOP; m_addr = '0; m_err = '0; m_ready = 0; ready_obs = 0;
    #1;
    for (int k = 0; k < DEPTH; k++) dut.u_array.mem[k] = 32'hA000_0000 + 32'(k);
    test_reset();
    test_back_to_back();
    test_stall();
    test_errors();
    test_flush();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
